demo_regbank: RTL and testbench
===============================

# demo_regbank

Parametrised AXI4-Lite register bank; second-generation demo peripheral. Terminates the AXI4-Lite channels directly with independent write and read state machines. Provides NUM_CTRL byte-strobed control registers driven onto fabric, a read-only version/config block, and an edge-triggered, maskable interrupt aggregator with write-1-to-clear pending bits.

## Interface
- ADDR_WIDTH, 16: AXI address width; only bits [ADDR_WIDTH-1:2] decoded, [1:0] ignored.
- NUM_CTRL, 4: control register count, 1..16.
- NUM_IRQ, 8: interrupt source count, 1..32.
- CTRL_RESET, 32'h0: reset value of every control register.
- i_axi_clk  in  1  clock; all logic rising-edge.
- i_axi_rst  in  1  reset; one clock, reset is synchronous and active-high.
- i_awvalid / o_awready  in/out  1  write address handshake; i_awaddr  in  ADDR_WIDTH.
- i_wvalid / o_wready  in/out  1  write data handshake; i_wdata  in  32; i_wstrb  in  4.
- o_bvalid / i_bready  out/in  1  write response handshake; o_bresp  out  2.
- i_arvalid / o_arready  in/out  1  read address handshake; i_araddr  in  ADDR_WIDTH.
- o_rvalid / i_rready  out/in  1  read response handshake; o_rresp  out  2; o_rdata  out  32.
- o_ctrl  out  32*NUM_CTRL  control registers, CTRL[k] at bits [32k+31:32k].
- o_ctrl_wr_stb  out  NUM_CTRL  one-cycle pulse per CTRL[k] write.
- i_irq_src  in  NUM_IRQ  interrupt sources, synchronous to i_axi_clk.
- o_irq  out  1  registered OR of enabled pending bits.

## Operation
- Address map (byte): 0x00 VERSION RO = 32'h2000_0000 (major 2 [31:28], minor 0 [27:20], rev 0 [19:16], pad 0); 0x04 CONFIG RO = {16'h0, NUM_IRQ[7:0], NUM_CTRL[7:0]}; 0x08 IRQ_PENDING RW1C; 0x0C IRQ_ENABLE RW; 0x10+4k CTRL[k], k<NUM_CTRL.
- Bits of IRQ_PENDING/IRQ_ENABLE at or above NUM_IRQ read 0, writes ignored.
- CTRL[k] and IRQ_ENABLE honour i_wstrb per byte; IRQ_PENDING clears bit i where wdata[i]=1 and its byte strobe set; RO writes ignored, bresp OKAY.
- Unmapped address: write discarded, bresp = 2'b10 (SLVERR); read returns 0, rresp = 2'b10. Mapped: resp 2'b00.
- Write FSM: WR_IDLE -> WR_EXEC -> WR_RESP -> WR_IDLE. In WR_IDLE, o_awready high until AW captured, o_wready high until W captured, in either order or same cycle. Both held -> WR_EXEC (one cycle; register updated at its closing edge, o_bvalid set) -> WR_RESP; o_bvalid held until i_bready; returns to WR_IDLE on bvalid&bready edge.
- Read FSM: RD_IDLE (o_arready=1) -> RD_EXEC -> RD_RESP -> RD_IDLE; independent of write FSM. o_rdata/o_rresp loaded at RD_EXEC closing edge, stable while o_rvalid high.
- o_ctrl_wr_stb[k]: high for the cycle after the CTRL[k] update edge, aligned with new o_ctrl value; fires even if i_wstrb=0.
- IRQ: src_d registers i_irq_src every cycle (including during reset). pending[i] sets on src & ~src_d. o_irq <= |(pending & enable).

## Timing
- Reset: all FSMs to IDLE, in-flight transactions dropped without response. While reset high, every output 0 except o_ctrl = CTRL_RESET replicated; pending, enable, o_irq, strobes 0. Readies rise on first edge with reset low.
- Write latency: last of AW/W handshake at edge N -> register updated and o_bvalid=1 at edge N+1; next AW/W accepted in the cycle after bvalid&bready.
- Read latency: AR handshake at edge N -> o_rvalid=1 at edge N+1.
- Throughput: max one write per 3 cycles and one read per 3 cycles with bready/rready held high.
- Read and write EXEC on same register in same cycle: read returns old value.
- IRQ set and W1C clear of same bit same cycle: set wins, bit remains 1.
- Source edge at cycle N -> pending at edge N+1 -> o_irq at edge N+2 if enabled; clearing last enabled pending bit drops o_irq one edge after the clear.
- Source held high through reset release: no pending set.
- i_bready/i_rready low: response held indefinitely; other FSM unaffected.

## Test plan
- Reset, read 0x00 and 0x04 with NUM_CTRL=4, NUM_IRQ=8 -> rdata 32'h2000_0000 and 32'h0000_0804, rresp 0, rvalid one edge after AR handshake.
- W before AW by 3 cycles, 0x14 data 32'hDEAD_BEEF, wstrb 4'b0101 over CTRL[1]=0 -> CTRL[1]=32'h00AD_00EF, o_ctrl_wr_stb=4'b0010 for one cycle, bresp 0.
- Write 0x40 and read 0x40 -> bresp 2'b10; rdata 0, rresp 2'b10; no o_ctrl change.
- IRQ_ENABLE=0x01, pulse i_irq_src[0] and [3] -> pending 0x09, o_irq 1 two edges after edge; write 0x08 with 0x01 -> pending 0x08, o_irq 0.
- W1C of bit 2 in same cycle as new edge on i_irq_src[2] -> pending[2] stays 1.
- Assert reset while o_bvalid high with bready low -> bvalid 0, CTRL back to CTRL_RESET, fresh write after reset completes normally.

Source files
------------

// File: rtl/demo_regbank.sv
// demo_regbank: AXI4-Lite register bank with byte-strobed control registers,
// a read-only version/config block and an edge-triggered maskable interrupt aggregator.
module demo_regbank #(
  parameter int          ADDR_WIDTH = 16,
  parameter int          NUM_CTRL   = 4,
  parameter int          NUM_IRQ    = 8,
  parameter logic [31:0] CTRL_RESET = 32'h0
) (
  input  logic                    i_axi_clk,
  input  logic                    i_axi_rst,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [ADDR_WIDTH-1:0]   i_awaddr,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  input  logic [31:0]             i_wdata,
  input  logic [3:0]              i_wstrb,
  output logic                    o_bvalid,
  input  logic                    i_bready,
  output logic [1:0]              o_bresp,
  input  logic                    i_arvalid,
  output logic                    o_arready,
  input  logic [ADDR_WIDTH-1:0]   i_araddr,
  output logic                    o_rvalid,
  input  logic                    i_rready,
  output logic [1:0]              o_rresp,
  output logic [31:0]             o_rdata,
  output logic [32*NUM_CTRL-1:0]  o_ctrl,
  output logic [NUM_CTRL-1:0]     o_ctrl_wr_stb,
  input  logic [NUM_IRQ-1:0]      i_irq_src,
  output logic                    o_irq
);

  localparam int                WORD_W      = ADDR_WIDTH - 2;
  localparam logic [31:0]       VERSION     = 32'h2000_0000;
  localparam logic [31:0]       CONFIG      = {16'h0, 8'(NUM_IRQ), 8'(NUM_CTRL)};
  localparam logic [WORD_W-1:0] W_VERSION   = WORD_W'(0);
  localparam logic [WORD_W-1:0] W_CONFIG    = WORD_W'(1);
  localparam logic [WORD_W-1:0] W_PEND      = WORD_W'(2);
  localparam logic [WORD_W-1:0] W_EN        = WORD_W'(3);
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_EXEC, WR_RESP} wrState_t;
  typedef enum logic [1:0] {RD_IDLE, RD_EXEC, RD_RESP} rdState_t;

  function automatic logic [31:0] strobeMerge(input logic [31:0] oldVal,
                                              input logic [31:0] newVal,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = oldVal;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = newVal[8*b +: 8];
    end
    return res;
  endfunction

  // Words 0..3 are fixed registers, then NUM_CTRL control words; nothing above.
  function automatic logic isMapped(input logic [WORD_W-1:0] word);
    return 32'(word) < 32'(4 + NUM_CTRL);
  endfunction

  wrState_t          wrState_q;
  logic              awHave_q, wHave_q, awReady_q, wReady_q, bValid_q;
  logic [1:0]        bResp_q;
  logic [WORD_W-1:0] wrWord_q;
  logic [31:0]       wData_q;
  logic [3:0]        wStrb_q;
  logic              awFire, wFire, wrExec;

  rdState_t          rdState_q;
  logic              arReady_q, rValid_q;
  logic [1:0]        rResp_q;
  logic [31:0]       rData_q;
  logic [WORD_W-1:0] rdWord_q;
  logic [31:0]       rdMux;
  logic              rdErr;

  logic [NUM_IRQ-1:0]  srcPrev_q, pending_q, enable_q;
  logic [NUM_IRQ-1:0]  srcRise, pendClr;
  logic                irq_q;
  logic [31:0]         ctrl_q [NUM_CTRL];
  logic [NUM_CTRL-1:0] ctrlStb_q;
  logic [31:0]         wrByteMask;
  logic                unusedAddrBits;

  assign awFire = awReady_q & i_awvalid;
  assign wFire  = wReady_q & i_wvalid;
  assign wrExec = (wrState_q == WR_EXEC);

  // AW and W are captured independently; EXEC starts once both are held.
  always_ff @(posedge i_axi_clk) begin
    if (i_axi_rst) begin
      wrState_q <= WR_IDLE;
      awHave_q  <= 1'b0;
      wHave_q   <= 1'b0;
      awReady_q <= 1'b0;
      wReady_q  <= 1'b0;
      bValid_q  <= 1'b0;
      bResp_q   <= RESP_OKAY;
      wrWord_q  <= '0;
      wData_q   <= '0;
      wStrb_q   <= '0;
    end else begin
      case (wrState_q)
        WR_IDLE: begin
          if (awFire) begin
            wrWord_q <= i_awaddr[ADDR_WIDTH-1:2];
            awHave_q <= 1'b1;
          end
          if (wFire) begin
            wData_q <= i_wdata;
            wStrb_q <= i_wstrb;
            wHave_q <= 1'b1;
          end
          if ((awHave_q | awFire) && (wHave_q | wFire)) begin
            wrState_q <= WR_EXEC;
            awReady_q <= 1'b0;
            wReady_q  <= 1'b0;
          end else begin
            awReady_q <= !(awHave_q | awFire);
            wReady_q  <= !(wHave_q | wFire);
          end
        end
        WR_EXEC: begin
          awHave_q  <= 1'b0;
          wHave_q   <= 1'b0;
          bValid_q  <= 1'b1;
          bResp_q   <= isMapped(wrWord_q) ? RESP_OKAY : RESP_SLVERR;
          wrState_q <= WR_RESP;
        end
        WR_RESP: begin
          if (i_bready) begin
            bValid_q  <= 1'b0;
            awReady_q <= 1'b1;
            wReady_q  <= 1'b1;
            wrState_q <= WR_IDLE;
          end
        end
        default: wrState_q <= WR_IDLE;
      endcase
    end
  end

  always_comb begin
    rdMux = '0;
    rdErr = !isMapped(rdWord_q);
    if (rdWord_q == W_VERSION) rdMux = VERSION;
    if (rdWord_q == W_CONFIG)  rdMux = CONFIG;
    if (rdWord_q == W_PEND)    rdMux = 32'(pending_q);
    if (rdWord_q == W_EN)      rdMux = 32'(enable_q);
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (rdWord_q == WORD_W'(4 + k)) rdMux = ctrl_q[k];
    end
  end

  // Read data is sampled from the pre-update register values, so a
  // concurrent write EXEC on the same word returns the old contents.
  always_ff @(posedge i_axi_clk) begin
    if (i_axi_rst) begin
      rdState_q <= RD_IDLE;
      arReady_q <= 1'b0;
      rValid_q  <= 1'b0;
      rResp_q   <= RESP_OKAY;
      rData_q   <= '0;
      rdWord_q  <= '0;
    end else begin
      case (rdState_q)
        RD_IDLE: begin
          if (arReady_q && i_arvalid) begin
            rdWord_q  <= i_araddr[ADDR_WIDTH-1:2];
            arReady_q <= 1'b0;
            rdState_q <= RD_EXEC;
          end else begin
            arReady_q <= 1'b1;
          end
        end
        RD_EXEC: begin
          rData_q   <= rdMux;
          rResp_q   <= rdErr ? RESP_SLVERR : RESP_OKAY;
          rValid_q  <= 1'b1;
          rdState_q <= RD_RESP;
        end
        RD_RESP: begin
          if (i_rready) begin
            rValid_q  <= 1'b0;
            arReady_q <= 1'b1;
            rdState_q <= RD_IDLE;
          end
        end
        default: rdState_q <= RD_IDLE;
      endcase
    end
  end

  always_comb begin
    wrByteMask = {{8{wStrb_q[3]}}, {8{wStrb_q[2]}}, {8{wStrb_q[1]}}, {8{wStrb_q[0]}}};
    srcRise    = i_irq_src & ~srcPrev_q;
    pendClr    = '0;
    if (wrExec && wrWord_q == W_PEND) pendClr = NUM_IRQ'(wData_q & wrByteMask);
  end

  // Kept running through reset so a source held high across release is not an edge.
  always_ff @(posedge i_axi_clk) begin
    srcPrev_q <= i_irq_src;
  end

  // New edges are OR-ed in after the clear, so a coincident set beats W1C.
  always_ff @(posedge i_axi_clk) begin
    if (i_axi_rst) begin
      for (int k = 0; k < NUM_CTRL; k++) ctrl_q[k] <= CTRL_RESET;
      ctrlStb_q <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      ctrlStb_q <= '0;
      pending_q <= (pending_q & ~pendClr) | srcRise;
      irq_q     <= |(pending_q & enable_q);
      if (wrExec) begin
        if (wrWord_q == W_EN) begin
          enable_q <= NUM_IRQ'(strobeMerge(32'(enable_q), wData_q, wStrb_q));
        end
        for (int k = 0; k < NUM_CTRL; k++) begin
          if (wrWord_q == WORD_W'(4 + k)) begin
            ctrl_q[k]    <= strobeMerge(ctrl_q[k], wData_q, wStrb_q);
            ctrlStb_q[k] <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_CTRL; k++) begin : gCtrlOut
    assign o_ctrl[32*k +: 32] = ctrl_q[k];
  end

  assign o_awready      = awReady_q;
  assign o_wready       = wReady_q;
  assign o_bvalid       = bValid_q;
  assign o_bresp        = bResp_q;
  assign o_arready      = arReady_q;
  assign o_rvalid       = rValid_q;
  assign o_rresp        = rResp_q;
  assign o_rdata        = rData_q;
  assign o_ctrl_wr_stb  = ctrlStb_q;
  assign o_irq          = irq_q;
  assign unusedAddrBits = ^{i_awaddr[1:0], i_araddr[1:0]};

endmodule

// File: tb/tb_demo_regbank.sv
// tb_demo_regbank: directed and randomized AXI4-Lite traffic against demo_regbank,
// checked with a word-level model of the register map.
module tb_demo_regbank;
  localparam int          ADDR_WIDTH = 16;
  localparam int          NUM_CTRL   = 4;
  localparam int          NUM_IRQ    = 8;
  localparam logic [31:0] CTRL_RESET = 32'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic                   awvalid, awready, wvalid, wready, bvalid, bready;
  logic                   arvalid, arready, rvalid, rready;
  logic [ADDR_WIDTH-1:0]  awaddr, araddr;
  logic [31:0]            wdata, rdata;
  logic [3:0]             wstrb;
  logic [1:0]             bresp, rresp;
  logic [32*NUM_CTRL-1:0] ctrl;
  logic [NUM_CTRL-1:0]    ctrlStb;
  logic [NUM_IRQ-1:0]     irqSrc;
  logic                   irq;

  demo_regbank #(
    .ADDR_WIDTH(ADDR_WIDTH), .NUM_CTRL(NUM_CTRL), .NUM_IRQ(NUM_IRQ), .CTRL_RESET(CTRL_RESET)
  ) dut (
    .i_axi_clk(clk), .i_axi_rst(rst),
    .i_awvalid(awvalid), .o_awready(awready), .i_awaddr(awaddr),
    .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata), .i_wstrb(wstrb),
    .o_bvalid(bvalid), .i_bready(bready), .o_bresp(bresp),
    .i_arvalid(arvalid), .o_arready(arready), .i_araddr(araddr),
    .o_rvalid(rvalid), .i_rready(rready), .o_rresp(rresp), .o_rdata(rdata),
    .o_ctrl(ctrl), .o_ctrl_wr_stb(ctrlStb), .i_irq_src(irqSrc), .o_irq(irq)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0]        mCtrl [NUM_CTRL];
  logic [NUM_IRQ-1:0] mEn, mPend;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal, input logic [31:0] newVal,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = oldVal;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = newVal[8*b +: 8];
    return r;
  endfunction

  function automatic logic [127:0] modelCtrlBus();
    logic [127:0] p;
    p = '0;
    for (int k = 0; k < NUM_CTRL; k++) p[32*k +: 32] = mCtrl[k];
    return p;
  endfunction

  // Returns {resp, data} for a read of the given byte address.
  function automatic logic [33:0] modelRead(input logic [15:0] addr);
    int w;
    w = int'(addr >> 2);
    if (w == 0) return {2'b00, 32'h2000_0000};
    if (w == 1) return {2'b00, 16'h0, 8'(NUM_IRQ), 8'(NUM_CTRL)};
    if (w == 2) return {2'b00, 32'(mPend)};
    if (w == 3) return {2'b00, 32'(mEn)};
    if (w >= 4 && w < 4 + NUM_CTRL) return {2'b00, mCtrl[w-4]};
    return {2'b10, 32'h0};
  endfunction

  function automatic logic [1:0] modelWrite(input logic [15:0] addr, input logic [31:0] data,
                                            input logic [3:0] strb);
    int w;
    w = int'(addr >> 2);
    if (w == 0 || w == 1) return 2'b00;
    if (w == 2) begin
      mPend = mPend & ~NUM_IRQ'(data & mergeBytes(32'h0, 32'hFFFF_FFFF, strb));
      return 2'b00;
    end
    if (w == 3) begin
      mEn = NUM_IRQ'(mergeBytes(32'(mEn), data, strb));
      return 2'b00;
    end
    if (w >= 4 && w < 4 + NUM_CTRL) begin
      mCtrl[w-4] = mergeBytes(mCtrl[w-4], data, strb);
      return 2'b00;
    end
    return 2'b10;
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < NUM_CTRL; k++) mCtrl[k] = CTRL_RESET;
    mEn   = '0;
    mPend = '0;
  endfunction

  // Full AXI write: AW/W start at independent cycle offsets; riseInExec raises
  // sources during the EXEC cycle; leaveOpen returns with the response pending.
  task automatic applyStimulus(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input int awStart, input int wStart, input int bDelay,
                               input logic [NUM_IRQ-1:0] riseInExec, input bit leaveOpen);
    bit awDone, wDone, hsAw, hsW;
    int c, w, waitCnt;
    logic [1:0] expResp;
    logic [NUM_CTRL-1:0] expStb;
    logic [NUM_IRQ-1:0] rise;
    awDone = 0; wDone = 0; c = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(awDone && wDone) && c < 64) begin
      awvalid = !awDone && (c >= awStart);
      wvalid  = !wDone && (c >= wStart);
      hsAw = awvalid && awready;
      hsW  = wvalid && wready;
      @(posedge clk); @(negedge clk);
      if (hsAw) awDone = 1;
      if (hsW) wDone = 1;
      c++;
    end
    awvalid = 0; wvalid = 0;
    checkOutput("aw_w_accepted", {awDone, wDone}, 2'b11);
    rise = riseInExec & ~irqSrc;
    irqSrc = irqSrc | riseInExec;
    w = int'(addr >> 2);
    expStb = (w >= 4 && w < 4 + NUM_CTRL) ? (NUM_CTRL'(1) << (w - 4)) : '0;
    expResp = modelWrite(addr, data, strb);
    mPend = mPend | rise;
    @(negedge clk);
    checkOutput("bvalid_latency", bvalid, 1'b1);
    waitCnt = 0;
    while (!bvalid && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("bresp", bresp, expResp);
    checkOutput("ctrl_wr_stb", ctrlStb, expStb);
    checkOutput("ctrl_value", ctrl, modelCtrlBus());
    if (!leaveOpen) begin
      for (int i = 0; i < bDelay; i++) begin
        @(negedge clk);
        checkOutput("bvalid_held", bvalid, 1'b1);
      end
      bready = 1;
      @(posedge clk); @(negedge clk);
      bready = 0;
      checkOutput("bvalid_drop", bvalid, 1'b0);
      checkOutput("ctrl_wr_stb_end", ctrlStb, '0);
    end
  endtask

  task automatic applyRead(input logic [15:0] addr, input int rDelay);
    logic [33:0] exp;
    bit done, hs;
    int c;
    done = 0; c = 0;
    araddr = addr;
    while (!done && c < 64) begin
      arvalid = 1;
      hs = arready;
      @(posedge clk); @(negedge clk);
      done = hs;
      c++;
    end
    arvalid = 0;
    checkOutput("ar_accepted", done, 1'b1);
    exp = modelRead(addr);
    @(negedge clk);
    checkOutput("rvalid_latency", rvalid, 1'b1);
    checkOutput("rdata", rdata, exp[31:0]);
    checkOutput("rresp", rresp, exp[33:32]);
    for (int i = 0; i < rDelay; i++) begin
      @(negedge clk);
      checkOutput("r_stable", {rvalid, rresp, rdata}, {1'b1, exp});
    end
    rready = 1;
    @(posedge clk); @(negedge clk);
    rready = 0;
    checkOutput("rvalid_drop", rvalid, 1'b0);
  endtask

  task automatic pulseIrq(input logic [NUM_IRQ-1:0] mask);
    mPend = mPend | (mask & ~irqSrc);
    irqSrc = irqSrc | mask;
    @(negedge clk);
    irqSrc = irqSrc & ~mask;
    @(negedge clk); @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] a;
    int op, word;
    rst = 1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; irqSrc = '0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset_readies", {awready, wready, arready}, 3'b000);
    checkOutput("reset_valids", {bvalid, rvalid, irq}, 3'b000);
    checkOutput("reset_ctrl", ctrl, {NUM_CTRL{CTRL_RESET}});
    checkOutput("reset_stb", ctrlStb, '0);
    rst = 0;
    @(negedge clk);
    checkOutput("readies_after_reset", {awready, wready, arready}, 3'b111);

    applyRead(16'h0000, 0);
    applyRead(16'h0004, 2);
    checkOutput("config_const", rdata, 32'h0000_0804);

    applyStimulus(16'h0014, 32'hDEAD_BEEF, 4'b0101, 3, 0, 1, '0, 0);
    checkOutput("ctrl1_merge", ctrl[63:32], 32'h00AD_00EF);

    applyStimulus(16'h0040, 32'h1234_5678, 4'hF, 0, 0, 0, '0, 0);
    applyRead(16'h0040, 1);

    applyStimulus(16'h000C, 32'h1, 4'hF, 1, 0, 0, '0, 0);
    irqSrc = 8'h09;
    mPend = mPend | 8'h09;
    @(negedge clk);
    checkOutput("irq_one_edge", irq, 1'b0);
    irqSrc = '0;
    @(negedge clk);
    checkOutput("irq_two_edges", irq, 1'b1);
    applyRead(16'h0008, 0);
    applyStimulus(16'h0008, 32'h1, 4'hF, 0, 0, 0, '0, 0);
    checkOutput("irq_after_clear", irq, 1'b0);
    applyRead(16'h0008, 0);

    applyStimulus(16'h0008, 32'h4, 4'hF, 0, 2, 0, 8'h04, 0);
    irqSrc = '0;
    applyRead(16'h0008, 0);
    checkOutput("set_beats_clear", rdata, 32'h0000_000C);
    applyStimulus(16'h0008, 32'hFF, 4'h1, 0, 0, 0, '0, 0);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      word = $urandom_range(0, 11);
      if (word == 10) word = 16'hFFFC >> 2;
      if (word == 11) word = 16;
      a = 16'(word << 2) | 16'($urandom_range(0, 3));
      if (op <= 1)
        applyStimulus(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), '0, 0);
      else if (op == 2)
        applyRead(a, $urandom_range(0, 3));
      else
        pulseIrq(NUM_IRQ'($urandom_range(1, 255)));
      checkOutput("irq_level", irq, |(mPend & mEn));
    end

    applyStimulus(16'h0010, 32'hCAFE_F00D, 4'hF, 0, 0, 0, '0, 1);
    rst = 1;
    irqSrc[5] = 1'b1;
    @(negedge clk);
    checkOutput("reset_drops_bvalid", bvalid, 1'b0);
    checkOutput("reset_ctrl_again", ctrl, {NUM_CTRL{CTRL_RESET}});
    checkOutput("reset_outputs", {awready, wready, arready, rvalid, irq, ctrlStb}, '0);
    @(negedge clk);
    rst = 0;
    modelReset();
    @(negedge clk);
    applyStimulus(16'h0018, 32'h0BAD_CAFE, 4'hF, 0, 1, 0, '0, 0);
    applyRead(16'h0018, 0);
    applyRead(16'h0008, 0);
    irqSrc = '0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
